// File: rtl/uart_transmitter_if.sv
// Host-side bundle of the UART transmitter: byte enqueue, parity control, serial line and status.
interface uart_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       parity_enable;
    logic       parity_odd_even;
    logic       tx_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       tx_busy;
    logic [2:0] current_state;

    modport master (
        output tx_data, tx_write, parity_enable, parity_odd_even,
        input  tx_out, fifo_empty, fifo_full, tx_busy, current_state
    );

    modport slave (
        input  tx_data, tx_write, parity_enable, parity_odd_even,
        output tx_out, fifo_empty, fifo_full, tx_busy, current_state
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit path: byte FIFO feeding a start / 8 data LSB-first / optional parity / stop serialiser,
// clocked by the 16x oversample tick shared with the receiver.
module uart_transmitter #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              enable,
    uart_transmitter_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [TICK_W-1:0] tick_cnt, tick_cnt_nxt;
    logic [2:0]        bit_idx, bit_idx_nxt;
    logic [7:0]        shift_reg, shift_reg_nxt;
    logic              par, par_nxt;
    logic              par_en, par_en_nxt;
    logic              tx_out_q, tx_out_nxt;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop, empty, full, bit_end;
    logic [7:0]        head;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign push    = bus.tx_write && !full;
    assign head    = mem[rd_ptr];
    assign bit_end = (tick_cnt == TICK_W'(OVERSAMPLE - 1));

    // FIFO storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par       <= 1'b0;
            par_en    <= 1'b0;
            tx_out_q  <= 1'b1;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_reg_nxt;
            par       <= par_nxt;
            par_en    <= par_en_nxt;
            tx_out_q  <= tx_out_nxt;
        end
    end

    // Line level follows the registered state, so it changes one clk after each state change.
    always_comb begin
        state_nxt     = state;
        tick_cnt_nxt  = tick_cnt;
        bit_idx_nxt   = bit_idx;
        shift_reg_nxt = shift_reg;
        par_nxt       = par;
        par_en_nxt    = par_en;
        tx_out_nxt    = 1'b1;
        pop           = 1'b0;

        if (state != IDLE) begin
            tick_cnt_nxt = bit_end ? '0 : tick_cnt + TICK_W'(1);
        end

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_out_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                tx_out_nxt = shift_reg[0];
                if (bit_end) begin
                    shift_reg_nxt = {1'b0, shift_reg[7:1]};
                    bit_idx_nxt   = bit_idx + 3'(1);
                    if (bit_idx == 3'd7) begin
                        state_nxt = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                tx_out_nxt = par;
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Parity settings are frozen per frame at the moment its byte leaves the FIFO.
        if (pop) begin
            shift_reg_nxt = head;
            par_en_nxt    = bus.parity_enable;
            par_nxt       = (^head) ^ bus.parity_odd_even;
        end
    end

    assign bus.tx_out        = tx_out_q;
    assign bus.fifo_empty    = empty;
    assign bus.fifo_full     = full;
    assign bus.tx_busy       = (state != IDLE);
    assign bus.current_state = state;
endmodule
